control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hard-wired Moore control unit for the 32-bit register-file CPU.
- Steps the fetch/execute T-states and drives the register select/encode controls (Gra, Grb, Grc, Rin, Rout, BAout), the bus-source/load enables, the ALU opcode and the memory strobes.
- Waits on a memory ready handshake and halts on the halt opcode.

Parameters:
- OPW, 5, opcode width, taken from instr[31:27].
- ADD_OP, 5'b00011, ALU code driven for address and branch-target arithmetic.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces state RST.
- instr  in  32  current IR contents; opcode = instr[31:27].
- con_ff  in  1  branch condition flip-flop output.
- mem_rdy  in  1  memory completed the current Read/Write this cycle.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to select/encode logic.
- PCout, Zlowout, MDRout, Cout  out  1 each  bus source enables.
- PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC  out  1 each  register load enables.
- Read, Write  out  1 each  memory strobes.
- alu_op  out  5  ALU operation code.
- run  out  1  high while executing; low in RST and HALTED.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- All outputs are a combinational decode of the state register plus the opcode.
- No output is ever X.
- In reset, every output is 0.
- Only state changes on the clock edge.
- States: RST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED.
- RST -> T0 on the first edge after reset deasserts.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin only on the entry cycle; Read and MDRin held every cycle. Stay in T1 while mem_rdy=0; go to T2 when mem_rdy=1.
  - T2: MDRout, IRin.
- T2 always goes to T3. T3 onwards is decoded from opcode.
- 3-reg ALU ops (add 00011 .. shl 01011):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op=opcode.
  - T5: Zlowout, Gra, Rin. Then -> T0.
- Immediate ALU ops (addi 01100 / andi 01101 / ori 01110), alu_op = add/and/or code respectively:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin.
  - T5: Zlowout, Gra, Rin. Then -> T0.
- ldi (00001):
  - T3: Grb, BAout, Yin.
  - T4: Cout, alu_op=ADD_OP, Zin.
  - T5: Zlowout, Gra, Rin. Then -> T0.
- ld (00000):
  - T3, T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; wait on mem_rdy as in T1.
  - T7: MDRout, Gra, Rin. Then -> T0.
- st (00010):
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write held until mem_rdy=1, then -> T0.
- br (10011):
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, alu_op=ADD_OP, Zin.
  - T6: if con_ff=1, Zlowout and PCin. Then -> T0 regardless.
- jr (10100): T3: Gra, Rout, PCin. Then -> T0.
- nop (11010): T3 drives nothing. Then -> T0.
- halt (11011): T3 -> HALTED. HALTED is absorbing, all strobes 0, run=0; only reset exits.
- Any other opcode: in T3 pulse illegal=1 for that cycle, otherwise behave as nop.
- alu_op is 0 in every state not listed above.
- Exclusivity rules:
  - At most one bus source (Rout/BAout, PCout, Zlowout, MDRout, Cout) per state.
  - Never Read and Write together.
  - At most one of Gra/Grb/Grc.
- mem_rdy is ignored outside T1, T6 (ld) and T7 (st).
- mem_rdy=1 on the entry cycle of a wait state advances after exactly one cycle.
- Reset mid-instruction, including in a wait state: immediately to RST, strobes drop asynchronously.

Decomposition:
- Shared package cpu_defs holds:
  - opcode localparams (OP_LD .. OP_HALT);
  - ADD_OP;
  - a state enum encoded 4-bit.
- Natural sub-module: op_class_decode (combinational) maps opcode to a one-hot class: ALU3, ALUI, LD, LDI, ST, BR, JR, NOP, HALT, ILL.
- The sequencer FSM consumes op_class_decode's class vector.

Test Plan:
- Reset deasserted, mem_rdy tied 1, instr=add r1,r2,r3 (0x18918000) -> states T0..T5 in 6 cycles; T4 drives Grc, Rout, Zin, alu_op=00011; T5 drives Gra, Rin.
- ld r1,0x55(r2) (opcode 00000) with mem_rdy low for 3 cycles in T6 -> Read, MDRin held 3 extra cycles; T7 drives Gra, Rin, MDRout; total 11 cycles, plus any T1 wait.
- st with mem_rdy=0 in T7 for 2 cycles -> Write held 3 cycles, never with Read; returns to T0.
- br: con_ff=0 -> T6 has PCin=0. con_ff=1 -> Zlowout=1 and PCin=1 in T6.
- halt (0xD8000000) -> run falls after T3 and the FSM stays HALTED for 20 cycles. A reset pulse -> run=0 in RST, then fetch resumes.
- Opcode 11111 -> illegal=1 for exactly one cycle (T3), next state T0. Reset asserted mid-T1 -> Read=0 the same cycle, asynchronously.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared CPU control definitions: opcodes, ALU codes, sequencer state encoding, opcode classes.
// Latency: none (types and constants only).
// Backpressure: none; memory waits are handled by the sequencer itself.
package cpu_defs;

  localparam int OPW = 5;

  // ALU code driven for address and branch-target arithmetic
  localparam logic [OPW-1:0] ADD_OP = 5'b00011;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10011;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_T7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  // One-hot opcode class vector, indexed by the CL_* positions
  localparam int NCLASS  = 10;
  localparam int CL_ALU3 = 0;
  localparam int CL_ALUI = 1;
  localparam int CL_LD   = 2;
  localparam int CL_LDI  = 3;
  localparam int CL_ST   = 4;
  localparam int CL_BR   = 5;
  localparam int CL_JR   = 6;
  localparam int CL_NOP  = 7;
  localparam int CL_HALT = 8;
  localparam int CL_ILL  = 9;

  typedef logic [NCLASS-1:0] op_class_t;

  // Immediate forms reuse the register-form ALU code of the same operation
  function automatic logic [OPW-1:0] imm_alu_op(input logic [OPW-1:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return ADD_OP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundles the sequencer's instruction/status inputs and all datapath control outputs.
// Latency: none (wires only).
// Backpressure: mem_rdy is the only handshake; the sequencer holds its strobes until it is seen.
interface control_sequencer_if;
  import cpu_defs::*;

  logic [31:0]    instr;
  logic           con_ff;
  logic           mem_rdy;

  logic           Gra, Grb, Grc, Rin, Rout, BAout;
  logic           PCout, Zlowout, MDRout, Cout;
  logic           PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC;
  logic           Read, Write;
  logic [OPW-1:0] alu_op;
  logic           run;
  logic           illegal;

  // Sequencer side: consumes instruction/status, drives controls
  modport master (
    input  instr, con_ff, mem_rdy,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output PCout, Zlowout, MDRout, Cout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC,
    output Read, Write, alu_op, run, illegal
  );

  // Datapath side: supplies instruction/status, consumes controls
  modport slave (
    output instr, con_ff, mem_rdy,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCout, Zlowout, MDRout, Cout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC,
    input  Read, Write, alu_op, run, illegal
  );

endinterface

// File: rtl/control_sequencer_op_class_decode.sv
// Maps a 5-bit opcode onto a one-hot instruction class vector.
// Latency: combinational, zero cycles.
// Backpressure: none.
module op_class_decode
  import cpu_defs::*;
(
  input  logic [OPW-1:0] opcode,
  output op_class_t      op_class
);

  // Exactly one class bit set for every opcode value; unknown opcodes land in ILL
  always_comb begin
    op_class = '0;
    if (opcode >= OP_ADD && opcode <= OP_SHL) begin
      op_class[CL_ALU3] = 1'b1;
    end else begin
      case (opcode)
        OP_ADDI, OP_ANDI, OP_ORI: op_class[CL_ALUI] = 1'b1;
        OP_LD:                    op_class[CL_LD]   = 1'b1;
        OP_LDI:                   op_class[CL_LDI]  = 1'b1;
        OP_ST:                    op_class[CL_ST]   = 1'b1;
        OP_BR:                    op_class[CL_BR]   = 1'b1;
        OP_JR:                    op_class[CL_JR]   = 1'b1;
        OP_NOP:                   op_class[CL_NOP]  = 1'b1;
        OP_HALT:                  op_class[CL_HALT] = 1'b1;
        default:                  op_class[CL_ILL]  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit: steps fetch/execute T-states and decodes datapath controls.
// Latency: controls are a combinational decode of the current state (plus opcode/con_ff).
// Backpressure: T1, ld-T6 and st-T7 hold their memory strobes until mem_rdy is sampled high.
module control_sequencer
  import cpu_defs::*;
(
  input  logic                clock,
  input  logic                reset,
  control_sequencer_if.master bus
);

  state_t         state_q, state_d;
  logic           t1_wait_q;
  op_class_t      cls;
  logic [OPW-1:0] opcode;

  assign opcode = bus.instr[31:27];

  op_class_decode u_decode (
    .opcode   (opcode),
    .op_class (cls)
  );

  // State register; t1_wait_q marks T1 cycles after the first so the PC update fires once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RST;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= (state_q == ST_T1) && !bus.mem_rdy;
    end
  end

  // Next-state and control decode; every output defaults to 0 so none can float to X
  always_comb begin
    state_d     = state_q;
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Grc     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.PCout   = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MDRout  = 1'b0;
    bus.Cout    = 1'b0;
    bus.PCin    = 1'b0;
    bus.IRin    = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.CONin   = 1'b0;
    bus.IncPC   = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.alu_op  = '0;
    bus.illegal = 1'b0;
    bus.run     = (state_q != ST_RST) && (state_q != ST_HALTED);

    unique case (state_q)
      ST_RST: state_d = ST_T0;

      ST_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = ST_T1;
      end

      ST_T1: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        if (!t1_wait_q) begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
        end
        if (bus.mem_rdy) state_d = ST_T2;
      end

      ST_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = ST_T3;
      end

      ST_T3: begin
        state_d = ST_T0;
        if (cls[CL_ALU3] || cls[CL_ALUI]) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
          state_d  = ST_T4;
        end else if (cls[CL_LD] || cls[CL_LDI] || cls[CL_ST]) begin
          bus.Grb   = 1'b1;
          bus.BAout = 1'b1;
          bus.Yin   = 1'b1;
          state_d   = ST_T4;
        end else if (cls[CL_BR]) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.CONin = 1'b1;
          state_d   = ST_T4;
        end else if (cls[CL_JR]) begin
          bus.Gra  = 1'b1;
          bus.Rout = 1'b1;
          bus.PCin = 1'b1;
        end else if (cls[CL_HALT]) begin
          state_d = ST_HALTED;
        end else if (cls[CL_ILL]) begin
          bus.illegal = 1'b1;
        end
      end

      ST_T4: begin
        state_d = ST_T5;
        if (cls[CL_ALU3]) begin
          bus.Grc    = 1'b1;
          bus.Rout   = 1'b1;
          bus.Zin    = 1'b1;
          bus.alu_op = opcode;
        end else if (cls[CL_ALUI]) begin
          bus.Cout   = 1'b1;
          bus.Zin    = 1'b1;
          bus.alu_op = imm_alu_op(opcode);
        end else if (cls[CL_LD] || cls[CL_LDI] || cls[CL_ST]) begin
          bus.Cout   = 1'b1;
          bus.Zin    = 1'b1;
          bus.alu_op = ADD_OP;
        end else if (cls[CL_BR]) begin
          bus.PCout = 1'b1;
          bus.Yin   = 1'b1;
        end else begin
          state_d = ST_T0;
        end
      end

      ST_T5: begin
        state_d = ST_T0;
        if (cls[CL_ALU3] || cls[CL_ALUI] || cls[CL_LDI]) begin
          bus.Zlowout = 1'b1;
          bus.Gra     = 1'b1;
          bus.Rin     = 1'b1;
        end else if (cls[CL_LD] || cls[CL_ST]) begin
          bus.Zlowout = 1'b1;
          bus.MARin   = 1'b1;
          state_d     = ST_T6;
        end else if (cls[CL_BR]) begin
          bus.Cout   = 1'b1;
          bus.Zin    = 1'b1;
          bus.alu_op = ADD_OP;
          state_d    = ST_T6;
        end
      end

      ST_T6: begin
        state_d = ST_T0;
        if (cls[CL_LD]) begin
          bus.Read  = 1'b1;
          bus.MDRin = 1'b1;
          state_d   = bus.mem_rdy ? ST_T7 : ST_T6;
        end else if (cls[CL_ST]) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.MDRin = 1'b1;
          state_d   = ST_T7;
        end else if (cls[CL_BR] && bus.con_ff) begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
        end
      end

      ST_T7: begin
        state_d = ST_T0;
        if (cls[CL_LD]) begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
        end else if (cls[CL_ST]) begin
          bus.Write = 1'b1;
          if (!bus.mem_rdy) state_d = ST_T7;
        end
      end

      ST_HALTED: state_d = ST_HALTED;

      default: state_d = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench: per-instruction micro-op lists are expanded into expected cycles.
// Latency: expected controls are compared every cycle at the falling edge.
// Backpressure: mem_rdy waits are scheduled by the model and driven cycle by cycle.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Expected-word bit positions, same order as observed()
  localparam logic [26:0] M_GRA   = 27'd1 << 26;
  localparam logic [26:0] M_GRB   = 27'd1 << 25;
  localparam logic [26:0] M_GRC   = 27'd1 << 24;
  localparam logic [26:0] M_RIN   = 27'd1 << 23;
  localparam logic [26:0] M_ROUT  = 27'd1 << 22;
  localparam logic [26:0] M_BAOUT = 27'd1 << 21;
  localparam logic [26:0] M_PCOUT = 27'd1 << 20;
  localparam logic [26:0] M_ZLOW  = 27'd1 << 19;
  localparam logic [26:0] M_MDROUT= 27'd1 << 18;
  localparam logic [26:0] M_COUT  = 27'd1 << 17;
  localparam logic [26:0] M_PCIN  = 27'd1 << 16;
  localparam logic [26:0] M_IRIN  = 27'd1 << 15;
  localparam logic [26:0] M_MARIN = 27'd1 << 14;
  localparam logic [26:0] M_MDRIN = 27'd1 << 13;
  localparam logic [26:0] M_YIN   = 27'd1 << 12;
  localparam logic [26:0] M_ZIN   = 27'd1 << 11;
  localparam logic [26:0] M_CONIN = 27'd1 << 10;
  localparam logic [26:0] M_INCPC = 27'd1 << 9;
  localparam logic [26:0] M_READ  = 27'd1 << 8;
  localparam logic [26:0] M_WRITE = 27'd1 << 7;
  localparam logic [26:0] M_RUN   = 27'd1 << 6;
  localparam logic [26:0] M_ILL   = 27'd1 << 5;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [26:0] exp_q[$];
  bit          rdy_q[$];
  logic [31:0] ins_q[$];
  bit          cf_q[$];
  logic [31:0] cur_instr;
  bit          cur_con;

  function automatic logic [26:0] observed();
    return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.PCout, bus.Zlowout,
            bus.MDRout, bus.Cout, bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.Zin,
            bus.CONin, bus.IncPC, bus.Read, bus.Write, bus.run, bus.illegal, bus.alu_op};
  endfunction

  function automatic bit rnd();
    return ($urandom_range(0, 1) == 1);
  endfunction

  // One executing cycle (run high); rdy is mem_rdy driven during that cycle
  task automatic push(input logic [26:0] w, input bit rdy);
    exp_q.push_back(w | M_RUN);
    rdy_q.push_back(rdy);
    ins_q.push_back(cur_instr);
    cf_q.push_back(cur_con);
  endtask

  task automatic push_idle();
    exp_q.push_back('0);
    rdy_q.push_back(rnd());
    ins_q.push_back(cur_instr);
    cf_q.push_back(cur_con);
  endtask

  // Memory wait: first cycle word, then `waits` extra cycles; mem_rdy rises on the last one
  task automatic push_wait(input logic [26:0] first, input logic [26:0] rest, input int waits);
    for (int j = 0; j <= waits; j++) push((j == 0) ? first : rest, j == waits);
  endtask

  // Reference model: expands one instruction into its expected per-cycle control words
  task automatic add_instr(input logic [31:0] ins, input bit cf, input int t1w, input int mw);
    logic [4:0]  op;
    logic [26:0] alu;
    cur_instr = ins;
    cur_con   = cf;
    op        = ins[31:27];
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, rnd());
    push_wait(M_ZLOW | M_PCIN | M_READ | M_MDRIN, M_READ | M_MDRIN, t1w);
    push(M_MDROUT | M_IRIN, rnd());
    if (op >= 5'd3 && op <= 5'd11) begin
      push(M_GRB | M_ROUT | M_YIN, rnd());
      push(M_GRC | M_ROUT | M_ZIN | 27'(op), rnd());
      push(M_ZLOW | M_GRA | M_RIN, rnd());
    end else if (op >= 5'd12 && op <= 5'd14) begin
      alu = (op == 5'd12) ? 27'd3 : (op == 5'd13) ? 27'd5 : 27'd6;
      push(M_GRB | M_ROUT | M_YIN, rnd());
      push(M_COUT | M_ZIN | alu, rnd());
      push(M_ZLOW | M_GRA | M_RIN, rnd());
    end else if (op <= 5'd2) begin
      push(M_GRB | M_BAOUT | M_YIN, rnd());
      push(M_COUT | M_ZIN | 27'd3, rnd());
      if (op == 5'd1) begin
        push(M_ZLOW | M_GRA | M_RIN, rnd());
      end else if (op == 5'd0) begin
        push(M_ZLOW | M_MARIN, rnd());
        push_wait(M_READ | M_MDRIN, M_READ | M_MDRIN, mw);
        push(M_MDROUT | M_GRA | M_RIN, rnd());
      end else begin
        push(M_ZLOW | M_MARIN, rnd());
        push(M_GRA | M_ROUT | M_MDRIN, rnd());
        push_wait(M_WRITE, M_WRITE, mw);
      end
    end else if (op == 5'd19) begin
      push(M_GRA | M_ROUT | M_CONIN, rnd());
      push(M_PCOUT | M_YIN, rnd());
      push(M_COUT | M_ZIN | 27'd3, rnd());
      push(cf ? (M_ZLOW | M_PCIN) : 27'd0, rnd());
    end else if (op == 5'd20) begin
      push(M_GRA | M_ROUT | M_PCIN, rnd());
    end else if (op == 5'd26 || op == 5'd27) begin
      push('0, rnd());
    end else begin
      push(M_ILL, rnd());
    end
  endtask

  // Plays the expected queue against the DUT, one comparison pair per cycle
  task automatic run_queue(input string name);
    logic [26:0] w, obs;
    bit          r;
    int          nsrc, nsel;
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      r = rdy_q.pop_front();
      @(posedge clock);
      @(negedge clock);
      bus.instr  = ins_q.pop_front();
      bus.con_ff = cf_q.pop_front();
      #1;
      cyc++;
      obs = observed();
      checks++;
      if (obs !== w) begin
        errors++;
        $display("FAIL %s cycle %0d: controls got %h expected %h", name, cyc, obs, w);
      end
      nsrc = int'(obs[22] | obs[21]) + int'(obs[20]) + int'(obs[19]) + int'(obs[18]) + int'(obs[17]);
      nsel = int'(obs[26]) + int'(obs[25]) + int'(obs[24]);
      checks++;
      if (nsrc > 1 || nsel > 1 || (obs[8] && obs[7])) begin
        errors++;
        $display("FAIL %s_exclusive cycle %0d: sources=%0d selects=%0d rd/wr=%b%b expected <=1,<=1,not both",
                 name, cyc, nsrc, nsel, obs[8], obs[7]);
      end
      bus.mem_rdy = r;
    end
  endtask

  // Holds reset over a falling edge, checks outputs are all zero, releases mid-cycle
  task automatic do_reset(input string name);
    reset = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (observed() !== 27'd0) begin
      errors++;
      $display("FAIL %s_in_reset: controls got %h expected 0", name, observed());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (observed() !== 27'd0) begin
      errors++;
      $display("FAIL %s_rst_state: controls got %h expected 0", name, observed());
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op);
    logic [31:0] v;
    v = $urandom;
    v[31:27] = op;
    return v;
  endfunction

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_alu();
    logic [4:0] op;
    add_instr(32'h18918000, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      op = 5'($urandom_range(3, 11));
      add_instr(mk(op), rnd(), $urandom_range(0, 2), 0);
    end
    run_queue("alu3");
  endtask

  task automatic test_imm();
    add_instr(mk(5'd12), 1'b0, 0, 0);
    add_instr(mk(5'd13), 1'b1, 1, 0);
    add_instr(mk(5'd14), 1'b0, 2, 0);
    add_instr(mk(5'd1), 1'b0, 0, 0);
    run_queue("imm_ldi");
  endtask

  task automatic test_ld();
    add_instr(32'h00900055, 1'b0, 0, 3);
    add_instr(mk(5'd0), 1'b1, 1, 0);
    run_queue("ld");
  endtask

  task automatic test_st();
    add_instr(mk(5'd2), 1'b0, 0, 2);
    add_instr(mk(5'd2), 1'b1, 0, 0);
    run_queue("st");
  endtask

  task automatic test_br();
    add_instr(mk(5'd19), 1'b0, 0, 0);
    add_instr(mk(5'd19), 1'b1, 1, 0);
    run_queue("br");
  endtask

  task automatic test_misc();
    add_instr(mk(5'd20), 1'b0, 0, 0);
    add_instr(mk(5'd26), 1'b0, 0, 0);
    add_instr(32'hF8000000, 1'b0, 0, 0);
    add_instr(mk(5'd15), 1'b1, 1, 0);
    add_instr(32'h18918000, 1'b0, 0, 0);
    run_queue("jr_nop_illegal");
  endtask

  task automatic test_halt();
    do_reset("halt_pre");
    add_instr(32'hD8000000, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) push_idle();
    run_queue("halt");
    do_reset("halt_exit");
    add_instr(32'h18918000, 1'b0, 1, 0);
    run_queue("after_halt");
  endtask

  task automatic test_async_reset();
    cur_instr = mk(5'd3);
    cur_con   = 1'b0;
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, rnd());
    push(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 1'b0);
    push(M_READ | M_MDRIN, 1'b0);
    run_queue("pre_async");
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.Read !== 1'b0 || observed() !== 27'd0) begin
      errors++;
      $display("FAIL async_reset: Read got %b controls %h expected Read 0 controls 0", bus.Read, observed());
    end
    do_reset("async_release");
    add_instr(mk(5'd2), 1'b1, 1, 1);
    run_queue("after_async");
  endtask

  task automatic test_random();
    logic [4:0] ops[15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd11, 5'd12, 5'd13, 5'd14,
                            5'd19, 5'd20, 5'd26, 5'd16, 5'd31, 5'd21};
    for (int i = 0; i < 40; i++) begin
      add_instr(mk(ops[$urandom_range(0, 14)]), rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_queue("random");
  endtask

  initial begin
    bus.instr   = 32'h0;
    bus.con_ff  = 1'b0;
    bus.mem_rdy = 1'b1;
    cur_instr   = 32'h0;
    cur_con     = 1'b0;
    test_reset();
    test_alu();
    test_imm();
    test_ld();
    test_st();
    test_br();
    test_misc();
    test_random();
    test_async_reset();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
